frame_depacketizer_axis: RTL and testbench
==========================================

// Module: frame_depacketizer_axis
// PURPOSE
//  Successor to the MIX-mode symbol depacketizer in the PSK receive chain; sits after carrier/symbol sync
//  and frame detection. Locks onto a frame start, strips a 32-bit BPSK header (MCS, length, signature),
//  corrects 180-deg ambiguity, packs BPSK/QPSK payload symbols into BYTES-wide AXI-Stream words with
//  tlast, and flags header, timeout and overflow errors. Holds one output word (tvalid/tready handshake).
// PARAMETERS
//  BYTES      1      output word width in bytes; BITS = 8*BYTES
//  LEN_WIDTH  16     width of header length field (counts payload WORDS); must be <= 16
//  SIGNATURE  8'hA5  required header signature byte
//  TIMEOUT_CC 1023   max clk cycles without in_valid inside HDR/PLD before abort; 0 disables timeout
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous active-high reset
//  in_valid     in   1       symbol strobe; in_sym is sampled only when high
//  in_sym       in   2       hard-decided symbol {I,Q}; header uses in_sym[1] only
//  sof          in   1       frame-start pulse from frame detector (one cycle)
//  sof_sgn      in   1       detected phase sign at sof; 1 = all bits inverted
//  data_tdata   out  BITS    packed payload word
//  data_tvalid  out  1       word valid
//  data_tready  in   1       downstream ready
//  data_tlast   out  1       high with final word of frame
//  data_tuser   out  1       = is_bpsk for the current word
//  is_bpsk      out  1       current payload modulation (1 BPSK, 0 QPSK)
//  busy         out  1       high in HDR or PLD
//  frame_done   out  1       1-cycle pulse: frame ended normally
//  err_sig      out  1       1-cycle pulse: signature mismatch
//  err_timeout  out  1       1-cycle pulse: in_valid gap exceeded TIMEOUT_CC
//  overflow     out  1       1-cycle pulse: word completed while previous word not yet accepted
// BEHAVIOUR
//  Reset: state=IDLE, all counters 0, data_tdata=0, tvalid/tlast/tuser=0, is_bpsk=1, sgn=0, all pulses 0.
//  States: IDLE -> HDR on sof (sgn<=sof_sgn, counters cleared). sof ignored outside IDLE.
//  HDR: 32 in_valid symbols, bit b = in_sym[1]^sgn, MSB first: MCS[7:0], LEN[15:0], SIG[7:0].
//   On 32nd symbol: SIG!=SIGNATURE -> err_sig, IDLE; LEN==0 -> frame_done, IDLE; else PLD,
//   is_bpsk<=MCS[7] (already sign-corrected). LEN bits above LEN_WIDTH are ignored.
//  PLD: each in_valid symbol corrected as in_sym^{sgn,sgn}; BPSK adds 1 bit (corrected in_sym[1]),
//   QPSK adds 2 bits {I,Q}; packed MSB-first (first symbol lands in tdata[BITS-1]).
//   Word completes after BITS (BPSK) or BITS/2 (QPSK) symbols; word count increments.
//  Output: completed word appears with tvalid=1 the cycle after its last symbol's in_valid;
//   held stable until tvalid&&tready; tlast=1 iff word index == LEN-1. Completion and acceptance in
//   the same cycle: new word loads, tvalid stays 1. Completion while held word unaccepted: new word
//   dropped, overflow pulse, count still advances (tlast frame framing preserved).
//  After last word completes: frame_done pulse, -> IDLE; pending word still drains via handshake.
//  Timeout: gap counter resets on in_valid; reaching TIMEOUT_CC in HDR/PLD -> err_timeout, IDLE,
//   partial word discarded (held complete word still drains).
//  is_bpsk returns to 1 on entry to IDLE; tuser latched per word at load time.
//  rst mid-frame: all outputs at reset values next cycle, held word discarded.
// TESTING
//  1 BYTES=1, sgn=0, hdr MCS=80 LEN=0002 SIG=A5, BPSK bits 10110010 01011111 -> B2 then 5F(tlast), tuser=1, frame_done.
//  2 MCS=00 LEN=0001, QPSK syms 11,00,10,01 -> single word C9 with tlast, tuser=0, is_bpsk=0 during PLD.
//  3 Repeat 1 with sof_sgn=1 and every input bit inverted -> identical output words B2, 5F.
//  4 Header SIG=A4 -> err_sig pulse after 32nd symbol, no tvalid, busy drops, next sof accepted.
//  5 Test 1 with tready=0 throughout -> B2 held, overflow pulse at 2nd completion, 5F never output.
//  6 LEN=0 -> frame_done, no tvalid; TIMEOUT_CC=8, stop in_valid mid-PLD -> err_timeout after 8 cycles; rst mid-PLD -> all outputs reset next cycle.

Source files
------------

// File: rtl/frame_depacketizer_axis.sv
`default_nettype none
// ============================================================================
//  Module      : frame_depacketizer_axis
//  Description : PSK receive-chain frame depacketizer. Locks onto a frame
//                start, strips a 32-bit BPSK header (MCS, length, signature),
//                removes the 180-degree phase ambiguity and packs BPSK/QPSK
//                payload symbols into AXI-Stream words with tlast. Flags
//                signature, timeout and overflow errors. One output word of
//                buffering (tvalid/tready handshake).
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_depacketizer_axis #(
  parameter int         BYTES      = 1,
  parameter int         LEN_WIDTH  = 16,
  parameter logic [7:0] SIGNATURE  = 8'hA5,
  parameter int         TIMEOUT_CC = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [1:0]           in_sym,
  input  logic                 sof,
  input  logic                 sof_sgn,
  output logic [8*BYTES-1:0]   data_tdata,
  output logic                 data_tvalid,
  input  logic                 data_tready,
  output logic                 data_tlast,
  output logic                 data_tuser,
  output logic                 is_bpsk,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_sig,
  output logic                 err_timeout,
  output logic                 overflow
);

  localparam int BITS  = 8 * BYTES;
  localparam int SYM_W = $clog2(BITS) + 1;
  // Gap counter only needs to reach TIMEOUT_CC-1; keep at least one bit.
  localparam int GAP_W = (TIMEOUT_CC < 2) ? 1 : $clog2(TIMEOUT_CC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PLD  = 2'd2
  } state_t;

  state_t               state;
  logic                 sgn;
  logic [4:0]           hdr_cnt;
  logic [30:0]          hdr_sr;
  logic [SYM_W-1:0]     sym_cnt;
  logic [LEN_WIDTH-1:0] word_cnt;
  logic [LEN_WIDTH-1:0] len;
  logic [BITS-1:0]      pack;
  logic [GAP_W-1:0]     gap_cnt;

  logic [1:0]           sym_c;
  logic [31:0]          hdr_full;
  logic [BITS-1:0]      pack_next;
  logic                 word_done;
  logic                 last_word;
  logic                 gap_hit;
  logic                 slot_free;

  // Phase-corrected symbol and the header/payload values it would produce
  assign sym_c     = in_sym ^ {sgn, sgn};
  assign hdr_full  = {hdr_sr, sym_c[1]};
  assign pack_next = is_bpsk ? {pack[BITS-2:0], sym_c[1]} : {pack[BITS-3:0], sym_c};
  assign word_done = is_bpsk ? (sym_cnt == SYM_W'(BITS - 1)) : (sym_cnt == SYM_W'(BITS/2 - 1));
  assign last_word = (word_cnt == len - LEN_WIDTH'(1));
  // A zero TIMEOUT_CC disables the watchdog entirely.
  assign gap_hit   = (TIMEOUT_CC != 0) && !in_valid && (gap_cnt == GAP_W'(TIMEOUT_CC - 1));
  // The output register can take a new word if empty or being drained now.
  assign slot_free = !data_tvalid || data_tready;
  assign busy      = (state != S_IDLE);

  // Frame FSM, header parser, payload packer and output word register
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      sgn         <= 1'b0;
      hdr_cnt     <= '0;
      hdr_sr      <= '0;
      sym_cnt     <= '0;
      word_cnt    <= '0;
      len         <= '0;
      pack        <= '0;
      gap_cnt     <= '0;
      data_tdata  <= '0;
      data_tvalid <= 1'b0;
      data_tlast  <= 1'b0;
      data_tuser  <= 1'b0;
      is_bpsk     <= 1'b1;
      frame_done  <= 1'b0;
      err_sig     <= 1'b0;
      err_timeout <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      err_sig     <= 1'b0;
      err_timeout <= 1'b0;
      overflow    <= 1'b0;

      // Downstream acceptance empties the slot; a same-cycle load below wins.
      if (data_tvalid && data_tready) begin
        data_tvalid <= 1'b0;
        data_tlast  <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (sof) begin
            state    <= S_HDR;
            sgn      <= sof_sgn;
            hdr_cnt  <= '0;
            sym_cnt  <= '0;
            word_cnt <= '0;
            gap_cnt  <= '0;
            pack     <= '0;
          end
        end

        S_HDR: begin
          if (in_valid) begin
            gap_cnt <= '0;
            hdr_sr  <= hdr_full[30:0];
            hdr_cnt <= hdr_cnt + 5'd1;
            if (hdr_cnt == 5'd31) begin
              if (hdr_full[7:0] != SIGNATURE) begin
                err_sig <= 1'b1;
                state   <= S_IDLE;
              end else if (hdr_full[8 +: LEN_WIDTH] == '0) begin
                frame_done <= 1'b1;
                state      <= S_IDLE;
              end else begin
                state   <= S_PLD;
                is_bpsk <= hdr_full[31];
                len     <= hdr_full[8 +: LEN_WIDTH];
              end
            end
          end else if (gap_hit) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
            is_bpsk     <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        S_PLD: begin
          if (in_valid) begin
            gap_cnt <= '0;
            if (word_done) begin
              sym_cnt  <= '0;
              pack     <= '0;
              word_cnt <= word_cnt + LEN_WIDTH'(1);
              if (slot_free) begin
                data_tdata  <= pack_next;
                data_tvalid <= 1'b1;
                data_tlast  <= last_word;
                data_tuser  <= is_bpsk;
              end else begin
                // Held word still pending: drop the new one but keep counting
                // so tlast still lands on the right word index.
                overflow <= 1'b1;
              end
              if (last_word) begin
                frame_done <= 1'b1;
                state      <= S_IDLE;
                is_bpsk    <= 1'b1;
              end
            end else begin
              sym_cnt <= sym_cnt + SYM_W'(1);
              pack    <= pack_next;
            end
          end else if (gap_hit) begin
            // Partial word is discarded; a held complete word still drains.
            err_timeout <= 1'b1;
            state       <= S_IDLE;
            is_bpsk     <= 1'b1;
            sym_cnt     <= '0;
            pack        <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_depacketizer_axis.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_depacketizer_axis
//  Description : Directed self-checking bench for frame_depacketizer_axis.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_depacketizer_axis;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_sym;
  logic       sof;
  logic       sof_sgn;
  logic [7:0] data_tdata;
  logic       data_tvalid;
  logic       data_tready;
  logic       data_tlast;
  logic       data_tuser;
  logic       is_bpsk;
  logic       busy;
  logic       frame_done;
  logic       err_sig;
  logic       err_timeout;
  logic       overflow;

  int vectors;
  int miscompares;

  frame_depacketizer_axis #(
    .BYTES      (1),
    .LEN_WIDTH  (16),
    .SIGNATURE  (8'hA5),
    .TIMEOUT_CC (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_sym      (in_sym),
    .sof         (sof),
    .sof_sgn     (sof_sgn),
    .data_tdata  (data_tdata),
    .data_tvalid (data_tvalid),
    .data_tready (data_tready),
    .data_tlast  (data_tlast),
    .data_tuser  (data_tuser),
    .is_bpsk     (is_bpsk),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_sig     (err_sig),
    .err_timeout (err_timeout),
    .overflow    (overflow)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [1:0] s);
    in_valid = 1'b1;
    in_sym   = s;
    tick();
    in_valid = 1'b0;
    in_sym   = 2'b00;
  endtask

  task automatic start_frame(input logic s);
    sof     = 1'b1;
    sof_sgn = s;
    tick();
    sof     = 1'b0;
    sof_sgn = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] h, input logic inv);
    for (int i = 31; i >= 0; i--) send_sym({h[i] ^ inv, inv});
  endtask

  task automatic send_bpsk_byte(input logic [7:0] b, input logic inv);
    for (int i = 7; i >= 0; i--) send_sym({b[i] ^ inv, 1'b0});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_sym      = 2'b00;
    sof         = 1'b0;
    sof_sgn     = 1'b0;
    data_tready = 1'b1;
    tick(); tick(); tick();

    // Reset state
    check("rst_tvalid", {31'd0, data_tvalid}, 32'd0);
    check("rst_tdata", {24'd0, data_tdata}, 32'd0);
    check("rst_is_bpsk", {31'd0, is_bpsk}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: BPSK frame, two words, sgn=0
    start_frame(1'b0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    send_hdr(32'h8000_02A5, 1'b0);
    check("t1_hdr_bpsk", {31'd0, is_bpsk}, 32'd1);
    send_bpsk_byte(8'hB2, 1'b0);
    check("t1_w0_valid", {31'd0, data_tvalid}, 32'd1);
    check("t1_w0_data", {24'd0, data_tdata}, 32'hB2);
    check("t1_w0_last", {31'd0, data_tlast}, 32'd0);
    check("t1_w0_user", {31'd0, data_tuser}, 32'd1);
    send_bpsk_byte(8'h5F, 1'b0);
    check("t1_w1_valid", {31'd0, data_tvalid}, 32'd1);
    check("t1_w1_data", {24'd0, data_tdata}, 32'h5F);
    check("t1_w1_last", {31'd0, data_tlast}, 32'd1);
    check("t1_done", {31'd0, frame_done}, 32'd1);
    check("t1_busy_end", {31'd0, busy}, 32'd0);
    tick();
    check("t1_drained", {31'd0, data_tvalid}, 32'd0);
    check("t1_done_pulse", {31'd0, frame_done}, 32'd0);

    // 2: QPSK frame, one word
    start_frame(1'b0);
    send_hdr(32'h0000_01A5, 1'b0);
    check("t2_is_qpsk", {31'd0, is_bpsk}, 32'd0);
    send_sym(2'b11);
    send_sym(2'b00);
    send_sym(2'b10);
    send_sym(2'b01);
    check("t2_valid", {31'd0, data_tvalid}, 32'd1);
    check("t2_data", {24'd0, data_tdata}, 32'hC9);
    check("t2_last", {31'd0, data_tlast}, 32'd1);
    check("t2_user", {31'd0, data_tuser}, 32'd0);
    check("t2_done", {31'd0, frame_done}, 32'd1);
    check("t2_bpsk_back", {31'd0, is_bpsk}, 32'd1);
    tick();

    // 3: inverted phase, everything inverted on the wire
    start_frame(1'b1);
    send_hdr(32'h8000_02A5, 1'b1);
    check("t3_hdr_bpsk", {31'd0, is_bpsk}, 32'd1);
    send_bpsk_byte(8'hB2, 1'b1);
    check("t3_w0_data", {24'd0, data_tdata}, 32'hB2);
    check("t3_w0_valid", {31'd0, data_tvalid}, 32'd1);
    send_bpsk_byte(8'h5F, 1'b1);
    check("t3_w1_data", {24'd0, data_tdata}, 32'h5F);
    check("t3_w1_last", {31'd0, data_tlast}, 32'd1);
    tick();

    // 4: bad signature, then a new frame with LEN=0
    start_frame(1'b0);
    send_hdr(32'h0000_01A4, 1'b0);
    check("t4_err_sig", {31'd0, err_sig}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_no_valid", {31'd0, data_tvalid}, 32'd0);
    tick();
    check("t4_err_pulse", {31'd0, err_sig}, 32'd0);
    start_frame(1'b0);
    check("t4_resof_busy", {31'd0, busy}, 32'd1);
    send_hdr(32'h8000_00A5, 1'b0);
    check("t6_len0_done", {31'd0, frame_done}, 32'd1);
    check("t6_len0_busy", {31'd0, busy}, 32'd0);
    check("t6_len0_valid", {31'd0, data_tvalid}, 32'd0);
    tick();

    // 5: downstream stalled -> overflow on second word
    data_tready = 1'b0;
    start_frame(1'b0);
    send_hdr(32'h8000_02A5, 1'b0);
    send_bpsk_byte(8'hB2, 1'b0);
    check("t5_w0_data", {24'd0, data_tdata}, 32'hB2);
    send_bpsk_byte(8'h5F, 1'b0);
    check("t5_overflow", {31'd0, overflow}, 32'd1);
    check("t5_held_data", {24'd0, data_tdata}, 32'hB2);
    check("t5_held_last", {31'd0, data_tlast}, 32'd0);
    check("t5_held_valid", {31'd0, data_tvalid}, 32'd1);
    check("t5_done", {31'd0, frame_done}, 32'd1);
    data_tready = 1'b1;
    tick();
    check("t5_ovf_pulse", {31'd0, overflow}, 32'd0);
    check("t5_drained", {31'd0, data_tvalid}, 32'd0);

    // 6b: payload stalls -> timeout after 8 idle cycles
    start_frame(1'b0);
    send_hdr(32'h8000_02A5, 1'b0);
    send_sym(2'b10);
    send_sym(2'b00);
    send_sym(2'b10);
    for (int i = 0; i < 7; i++) tick();
    check("t6_pre_timeout", {31'd0, err_timeout}, 32'd0);
    check("t6_pre_busy", {31'd0, busy}, 32'd1);
    tick();
    check("t6_timeout", {31'd0, err_timeout}, 32'd1);
    check("t6_to_busy", {31'd0, busy}, 32'd0);
    check("t6_to_valid", {31'd0, data_tvalid}, 32'd0);
    tick();
    check("t6_to_pulse", {31'd0, err_timeout}, 32'd0);

    // 6c: reset mid-payload with a held word
    data_tready = 1'b0;
    start_frame(1'b0);
    send_hdr(32'h0000_02A5, 1'b0);
    send_sym(2'b11);
    send_sym(2'b00);
    send_sym(2'b10);
    send_sym(2'b01);
    check("t6_held_valid", {31'd0, data_tvalid}, 32'd1);
    check("t6_held_data", {24'd0, data_tdata}, 32'hC9);
    send_sym(2'b01);
    rst = 1'b1;
    tick();
    check("t6_rst_valid", {31'd0, data_tvalid}, 32'd0);
    check("t6_rst_data", {24'd0, data_tdata}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_bpsk", {31'd0, is_bpsk}, 32'd1);
    check("t6_rst_user", {31'd0, data_tuser}, 32'd0);
    rst = 1'b0;
    data_tready = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
